// File: rtl/seqdet_rr_sched.sv
// Round-robin scheduler sharing one overlapping 1101 Moore detector
// among NREQ requesters; reports a saturating count per frame.
module seqdet_rr_sched #(
  parameter int NREQ      = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*FRAME_LEN-1:0] frame_data,
  output logic [NREQ-1:0]           gnt,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NREQ)-1:0]   done_id,
  output logic [CNT_W-1:0]          det_count
);

  localparam int IDW = $clog2(NREQ);
  localparam int BCW = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE, GRANT, SHIFT, DONE
  } st_t;

  typedef enum logic [2:0] {
    S0, S1, S2, S3, S4
  } det_t;

  st_t                  state_q, state_d;
  det_t                 det_q, det_d, det_nx;
  logic [IDW-1:0]       last_q, last_d;
  logic [IDW-1:0]       win_q, win_d;
  logic [FRAME_LEN-1:0] sh_q, sh_d;
  logic [BCW-1:0]       bit_q, bit_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]      gnt_q, gnt_d;
  logic                 done_q, done_d;
  logic [IDW-1:0]       done_id_q, done_id_d;
  logic [CNT_W-1:0]     det_count_q, det_count_d;

  logic                 found;
  logic [IDW-1:0]       rr_win;
  logic [IDW-1:0]       idx;
  logic [FRAME_LEN-1:0] rr_frame;

  function automatic det_t det_next(det_t s, logic b);
    det_t n;
    n = S0;
    unique case (s)
      S0: n = b ? S1 : S0;
      S1: n = b ? S2 : S0;
      S2: n = b ? S2 : S3;
      S3: n = b ? S4 : S0;
      S4: n = b ? S2 : S0;
      default: n = S0;
    endcase
    return n;
  endfunction

  // Search starts one past the last winner and wraps.
  always_comb begin
    found  = 1'b0;
    rr_win = last_q;
    idx    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(last_q) + i) % NREQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        rr_win = idx;
      end
    end
  end

  always_comb begin
    rr_frame = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rr_win == IDW'(i)) begin
        rr_frame = frame_data[i*FRAME_LEN +: FRAME_LEN];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    det_d       = det_q;
    last_d      = last_q;
    win_d       = win_q;
    sh_d        = sh_q;
    bit_d       = bit_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    det_count_d = det_count_q;
    det_nx      = det_next(det_q, sh_q[FRAME_LEN-1]);
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = NREQ'(1) << rr_win;
          win_d   = rr_win;
          last_d  = rr_win;
          sh_d    = rr_frame;
          det_d   = S0;
          bit_d   = '0;
          cnt_d   = '0;
        end
      end
      GRANT: state_d = SHIFT;
      SHIFT: begin
        det_d = det_nx;
        sh_d  = sh_q << 1;
        bit_d = bit_q + 1'b1;
        if (det_nx == S4 && cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (bit_q == BCW'(FRAME_LEN-1)) begin
          state_d     = DONE;
          bit_d       = '0;
          done_d      = 1'b1;
          done_id_d   = win_q;
          det_count_d = cnt_d;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      det_q       <= S0;
      last_q      <= IDW'(NREQ-1);
      win_q       <= '0;
      sh_q        <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      det_count_q <= '0;
    end else begin
      state_q     <= state_d;
      det_q       <= det_d;
      last_q      <= last_d;
      win_q       <= win_d;
      sh_q        <= sh_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      det_count_q <= det_count_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign det_count = det_count_q;

endmodule

// File: tb/tb_seqdet_rr_sched.sv
// Scoreboard bench for seqdet_rr_sched: a transaction-level model
// predicts grant/done cycles and counts; a negedge monitor compares.
module tb_seqdet_rr_sched;

  localparam int NREQ = 4;
  localparam int FL   = 8;
  localparam int CW   = 4;
  localparam int SFL  = 16;
  localparam int SCW  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*FL-1:0] frame_data = '0;
  logic [NREQ-1:0] gnt;
  logic            busy, done;
  logic [1:0]      done_id;
  logic [CW-1:0]   det_count;

  logic [1:0]      s_req = '0;
  logic [2*SFL-1:0] s_frame = '0;
  logic [1:0]      s_gnt;
  logic            s_busy, s_done;
  logic            s_id;
  logic [SCW-1:0]  s_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seqdet_rr_sched #(.NREQ(NREQ), .FRAME_LEN(FL), .CNT_W(CW)) u_dut (
    .clk(clk), .reset_n(rst_n), .req(req), .frame_data(frame_data),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .det_count(det_count)
  );

  seqdet_rr_sched #(.NREQ(2), .FRAME_LEN(SFL), .CNT_W(SCW)) u_sat (
    .clk(clk), .reset_n(rst_n), .req(s_req), .frame_data(s_frame),
    .gnt(s_gnt), .busy(s_busy), .done(s_done), .done_id(s_id),
    .det_count(s_cnt)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Count every 1101 window scanning MSB first, then saturate.
  function automatic int cnt1101(logic [63:0] f, int len, int w);
    int c = 0;
    for (int i = len - 1; i >= 3; i--)
      if (f[i] && f[i-1] && !f[i-2] && f[i-3]) c++;
    if (c > (1 << w) - 1) c = (1 << w) - 1;
    return c;
  endfunction

  typedef struct { int cyc; logic [NREQ-1:0] vec; } gexp_t;
  typedef struct { int cyc; int id; int cnt; } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];
  int    sq[$];
  int    cyc, free_at, last, busy_lo, busy_hi, hid, hcnt;

  // Transaction model: one frame occupies FL+3 cycles from the sampling cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gq.delete(); dq.delete();
      cyc = 0; free_at = 0; last = NREQ - 1;
      busy_lo = -1; busy_hi = -2; hid = 0; hcnt = 0;
    end else begin
      if (cyc >= free_at && req != 0) begin
        int w;
        logic [63:0] fr;
        w = -1;
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && req[(last + k) % NREQ]) w = (last + k) % NREQ;
        fr = 64'(frame_data[w*FL +: FL]);
        gq.push_back('{cyc + 1, NREQ'(1) << w});
        dq.push_back('{cyc + FL + 2, w, cnt1101(fr, FL, CW)});
        busy_lo = cyc + 1;
        busy_hi = cyc + FL + 2;
        free_at = cyc + FL + 3;
        last = w;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    logic [NREQ-1:0] eg;
    logic ed;
    eg = '0;
    if (gq.size() > 0 && gq[0].cyc == cyc) begin
      eg = gq[0].vec;
      void'(gq.pop_front());
    end
    chk("gnt", 32'(gnt), 32'(eg));
    ed = 1'b0;
    if (dq.size() > 0 && dq[0].cyc == cyc) begin
      ed = 1'b1;
      hid = dq[0].id;
      hcnt = dq[0].cnt;
      void'(dq.pop_front());
    end
    chk("done", 32'(done), 32'(ed));
    chk("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
    chk("done_id", 32'(done_id), 32'(hid));
    chk("det_count", 32'(det_count), 32'(hcnt));
    if (s_done) begin
      if (sq.size() == 0) chk("sat_unexpected_done", 32'(s_done), 32'(0));
      else begin
        chk("sat_cnt", 32'(s_cnt), 32'(sq.pop_front()));
        chk("sat_id", 32'(s_id), 32'(0));
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sat_frame(logic [SFL-1:0] f);
    s_frame[SFL-1:0] = f;
    s_req = 2'b01;
    sq.push_back(cnt1101(64'(f), SFL, SCW));
    cycles(1);
    s_req = 2'b00;
  endtask

  initial begin
    cycles(2);
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_det_count", 32'(det_count), 32'(0));
    #2 rst_n = 1'b1;

    cycles(2);
    frame_data[0 +: FL] = 8'b11011010;
    req = 4'b0001;
    fork
      sat_frame(16'b1101101101101101);
    join_none
    cycles(1);
    req = '0;
    cycles(14);

    frame_data[2*FL +: FL] = 8'h00;
    req = 4'b0100;
    cycles(1);
    req = '0;
    cycles(14);
    frame_data[2*FL +: FL] = 8'hFF;
    req = 4'b0100;
    cycles(1);
    req = '0;
    cycles(14);

    for (int i = 0; i < NREQ; i++) frame_data[i*FL +: FL] = 8'b11010000;
    req = 4'b1111;
    fork
      sat_frame(16'($urandom));
    join_none
    cycles(5 * 11);
    req = '0;
    cycles(14);

    req = 4'b0010;
    cycles(1);
    req = '0;
    cycles(3);
    req = 4'b0001;
    cycles(25);
    req = '0;
    cycles(5);

    req = 4'b0011;
    cycles(6);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'(0));
    chk("async_rst_busy", 32'(busy), 32'(0));
    chk("async_rst_done", 32'(done), 32'(0));
    chk("async_rst_id", 32'(done_id), 32'(0));
    chk("async_rst_cnt", 32'(det_count), 32'(0));
    cycles(2);
    #2 rst_n = 1'b1;
    cycles(15);
    req = '0;
    cycles(14);

    for (int n = 0; n < 400; n++) begin
      cycles(1);
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
      if ($urandom_range(0, 1) == 1)
        frame_data[$urandom_range(0, NREQ-1)*FL +: FL] = FL'($urandom);
    end
    req = '0;
    cycles(30);
    chk("drain_main", 32'(gq.size() + dq.size()), 32'(0));
    chk("drain_sat", 32'(sq.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seqdet_rr_sched.md
# seqdet_rr_sched

Round-robin scheduler that shares one 1101 overlapping Moore sequence detector among `NREQ` requesters. Each requester presents a parallel frame of `FRAME_LEN` bits. On grant, the block latches that frame, serializes it MSB-first through the internal detector, and counts overlapping `1101` occurrences. It then reports the count with the requester ID. The block sits between the frame producers and the detection-result consumer, so no requester ever drives the detector directly.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, ≥2.
- `FRAME_LEN`, 8: bits per frame, ≥4.
- `CNT_W`, 4: detection counter width; the counter saturates.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req`, in, `NREQ`: per-requester request, level.
- `frame_data`, in, `NREQ*FRAME_LEN`: requester i's frame at `[i*FRAME_LEN +: FRAME_LEN]`, transmitted MSB first.
- `gnt`, out, `NREQ`: one-hot grant pulse, one cycle, at the cycle the frame is latched.
- `busy`, out, 1: high while the FSM is not in IDLE.
- `done`, out, 1: one-cycle pulse when a frame result is valid.
- `done_id`, out, `$clog2(NREQ)`: index of the requester whose frame finished. Held until the next `done`.
- `det_count`, out, `CNT_W`: saturating overlapping-1101 count for that frame. Held until the next `done`.

## Operation
- Scheduler FSM states: IDLE, GRANT, SHIFT, DONE.
- **IDLE**
  - `busy`=0.
  - If any `req` bit is set, select the winner by round-robin, searching from `(last+1) mod NREQ` upward with wrap.
  - Next state is GRANT.
- **GRANT**
  - `gnt[winner]`=1 for this cycle only.
  - Latch the winner's frame into the shift register.
  - Clear the detector to S0, the bit counter to 0 and the running count to 0.
  - Set `last`=winner.
  - Go to SHIFT.
- **SHIFT**
  - Each cycle, feed the shift-register MSB to the detector and shift left.
  - Bit counter counts 0..FRAME_LEN-1. After bit FRAME_LEN-1, go to DONE.
- **DONE**
  - `done`=1.
  - Load `done_id` and `det_count` from the running values.
  - Return to IDLE.
- Detector: Moore FSM with states S0, S1 ("1"), S2 ("11"), S3 ("110"), S4 ("1101"). Overlapping transitions:
  - S0: 1→S1, 0→S0.
  - S1: 1→S2, 0→S0.
  - S2: 1→S2, 0→S3.
  - S3: 1→S4, 0→S0.
  - S4: 1→S2, 0→S0.
- Running count increments on every clock edge at which the detector enters S4. It saturates at 2^CNT_W−1 and never wraps.
- Detections never span frames: the detector is cleared in GRANT.
- Round-robin pointer `last` resets to NREQ−1, so req0 has first priority after reset.
- `req` is sampled only in IDLE. A requester may drop `req` after its `gnt` pulse. Changes to `req` or `frame_data` during GRANT/SHIFT/DONE are ignored.
- A requester that holds `req` high is re-served only after every other active requester has been served once.

## Timing
- Reset values (`reset_n`=0, asynchronous):
  - FSM state IDLE, detector S0, `last`=NREQ−1.
  - `gnt`=0, `busy`=0, `done`=0, `done_id`=0, `det_count`=0.
  - Shift register, bit counter and running count all 0.
- `req` seen in IDLE at cycle T:
  - `gnt` high in cycle T+1.
  - Bits consumed in cycles T+2..T+FRAME_LEN+1.
  - `done` high in cycle T+FRAME_LEN+2.
  - Back in IDLE at T+FRAME_LEN+3.
  - The earliest next `gnt` is T+FRAME_LEN+4, giving a back-to-back period of FRAME_LEN+3 cycles.
- `busy` is high from the GRANT cycle through the DONE cycle inclusive.
- `done_id`/`det_count` update in the same cycle `done` rises and are stable otherwise.
- Reset mid-frame: all state clears immediately and no `done` is produced for the aborted frame. After release, the first grant goes to the lowest-index active requester.
- When no request is pending, the FSM stays in IDLE with all pulses low.

## Test plan
- req=0001, frame0=8'b11011010, others idle:
  - `gnt`=0001 once.
  - `done` pulses FRAME_LEN+1 cycles after `gnt`, with `done_id`=0 and `det_count`=2 (overlap at bit offsets 0 and 3).
- req=0100, frame2=8'h00, then a second request with frame2=8'hFF:
  - Both frames give `done_id`=2 and `det_count`=0.
  - `det_count` stays unchanged between the two `done` pulses.
- req=1111 held continuously, all frames 8'b11010000:
  - Grants in the order 0001, 0010, 0100, 1000, 0001, each spaced 11 cycles apart.
  - Every `det_count`=1, and `done_id` follows the grant order.
- FRAME_LEN=16, CNT_W=2, frame0=16'b1101101101101101:
  - The frame contains 5 raw occurrences; `det_count` saturates at 3 without wrapping.
- req=0011, with `reset_n` pulsed low 4 cycles after `gnt`=0001:
  - All outputs are 0 immediately and no `done` is produced.
  - After release, `gnt`=0001 (pointer reset), followed by a normal `done` with `done_id`=0.
- req1 raised alone, then req0 raised during SHIFT:
  - req0 is ignored until IDLE.
  - Next `gnt`=0001, issued 2 cycles after req1's `done`.
